// File: rtl/ssd_scan_ctrl.sv
// Seven-segment scan controller: walks one shared decoder across DIGITS positions with a blank guard per slot.
// Define SSD_LZS_EN to blank leading zero digits (digit 0 is always shown).
module ssd_scan_ctrl #(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 50000,
  parameter int GUARD    = 500
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  load_valid,
  input  logic [4*DIGITS-1:0]   load_data,
  output logic                  load_ready,
  output logic [3:0]            nibble,
  output logic [DIGITS-1:0]     digit_sel,
  output logic                  frame_done
);

  localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(PRESCALE - 1);
  localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'((GUARD > 0) ? GUARD - 1 : 0);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(DIGITS - 1);

  localparam logic [0:0] ST_GUARD = 1'b0;
  localparam logic [0:0] ST_DRIVE = 1'b1;

  logic [0:0]          state_q,   state_d;
  logic [CNT_W-1:0]    cnt_q,     cnt_d;
  logic [IDX_W-1:0]    idx_q,     idx_d;
  logic [4*DIGITS-1:0] active_q,  active_d;
  logic [4*DIGITS-1:0] shadow_q,  shadow_d;
  logic                pending_q, pending_d;
  logic                ready_q,   ready_d;
  logic [3:0]          nibble_q,  nibble_d;
  logic [DIGITS-1:0]   sel_q,     sel_d;
  logic                frame_q,   frame_d;

  logic slotWrap;
  logic lastDigit;
  logic boundary;
  logic commit;
  logic transfer;

  assign slotWrap  = (cnt_q == CNT_LAST);
  assign lastDigit = (idx_q == IDX_LAST);
  assign boundary  = en && slotWrap && lastDigit;
  assign commit    = boundary && pending_q;
  assign transfer  = load_valid && ready_q;

  // Slot timing: counter, digit index and guard/drive phase all freeze while en is low.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    if (en) begin
      if (slotWrap) begin
        cnt_d = '0;
        idx_d = lastDigit ? '0 : idx_q + IDX_W'(1);
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      if (GUARD == 0) begin
        state_d = ST_DRIVE;
      end else if (slotWrap) begin
        state_d = ST_GUARD;
      end else if (state_q == ST_GUARD && cnt_q == GUARD_LAST) begin
        state_d = ST_DRIVE;
      end
    end
  end

  // The shadow only moves into the active register at a frame boundary, so a frame never tears.
  always_comb begin
    active_d  = active_q;
    shadow_d  = shadow_q;
    pending_d = pending_q;
    if (commit) begin
      active_d  = shadow_q;
      pending_d = 1'b0;
    end else if (transfer) begin
      shadow_d  = load_data;
      pending_d = 1'b1;
    end
    ready_d = !pending_d;
    frame_d = boundary;
  end

  always_comb begin
    logic blank;
`ifdef SSD_LZS_EN
    logic zeroFrom;
    zeroFrom = 1'b1;
`endif
    blank    = 1'b0;
    nibble_d = '0;
    sel_d    = '0;
    // Walk from the most significant digit so zeroFrom tracks "this digit and all above are zero".
    for (int k = DIGITS - 1; k >= 0; k--) begin
`ifdef SSD_LZS_EN
      zeroFrom = zeroFrom && (active_d[4*k +: 4] == 4'h0);
`endif
      if (idx_d == IDX_W'(k)) begin
        nibble_d = active_d[4*k +: 4];
`ifdef SSD_LZS_EN
        blank = (k > 0) && zeroFrom;
`endif
        sel_d[k] = en && (state_d == ST_DRIVE) && !blank;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_GUARD;
      cnt_q     <= '0;
      idx_q     <= '0;
      active_q  <= '0;
      shadow_q  <= '0;
      pending_q <= 1'b0;
      ready_q   <= 1'b1;
      nibble_q  <= '0;
      sel_q     <= '0;
      frame_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      active_q  <= active_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      ready_q   <= ready_d;
      nibble_q  <= nibble_d;
      sel_q     <= sel_d;
      frame_q   <= frame_d;
    end
  end

  assign load_ready = ready_q;
  assign nibble     = nibble_q;
  assign digit_sel  = sel_q;
  assign frame_done = frame_q;

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Scoreboard bench for ssd_scan_ctrl with DIGITS=4, PRESCALE=8, GUARD=2; expectations come from a position-based model.
module tb_ssd_scan_ctrl;

   localparam int DIGITS   = 4;
   localparam int PRESCALE = 8;
   localparam int GUARD    = 2;
   localparam int FRAME    = DIGITS * PRESCALE;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        en = 1'b0;
   logic        load_valid = 1'b0;
   logic [15:0] load_data = 16'h0;
   logic        load_ready;
   logic [3:0]  nibble;
   logic [3:0]  digit_sel;
   logic        frame_done;

   typedef struct packed {
      logic [3:0] sel;
      logic [3:0] nib;
      logic       fd;
      logic       rdy;
   } expT;

   expT expQ[$];

   int checks = 0;
   int errors = 0;

   // Model: scanPos counts enabled edges since reset, so slot and offset fall straight out of it.
   int          scanPos = 0;
   logic [15:0] modelActive = 16'h0;
   logic [15:0] modelShadow = 16'h0;
   logic        modelPending = 1'b0;
   logic        offerOn = 1'b0;
   logic [15:0] offerData = 16'h0;

   ssd_scan_ctrl #(.DIGITS(DIGITS), .PRESCALE(PRESCALE), .GUARD(GUARD)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .en(en),
      .load_valid(load_valid),
      .load_data(load_data),
      .load_ready(load_ready),
      .nibble(nibble),
      .digit_sel(digit_sel),
      .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   // Bounds the whole run so a stuck bench still reports.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: observed timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, observed, expected, $time);
      end
   endtask

   task automatic startOffer(input logic [15:0] value);
      offerOn   = 1'b1;
      offerData = value;
   endtask

   // One clock cycle: drive inputs, predict the post-edge outputs, then compare after the edge.
   task automatic applyStimulus(input logic enIn);
      expT  e;
      expT  got;
      logic boundary;
      logic xfer;
      int   slot;
      int   offset;
      en         = enIn;
      load_valid = offerOn;
      load_data  = offerData;
      xfer       = offerOn && !modelPending;
      boundary   = enIn && ((scanPos % FRAME) == FRAME - 1);
      if (enIn) scanPos++;
      if (boundary && modelPending) begin
         modelActive  = modelShadow;
         modelPending = 1'b0;
      end else if (xfer) begin
         modelShadow  = offerData;
         modelPending = 1'b1;
      end
      slot   = (scanPos / PRESCALE) % DIGITS;
      offset = scanPos % PRESCALE;
      e.sel  = (enIn && offset >= GUARD) ? 4'(1 << slot) : 4'b0;
`ifdef SSD_LZS_EN
      if (slot > 0 && (modelActive >> (4 * slot)) == 16'h0) e.sel = 4'b0;
`endif
      e.nib = modelActive[4*slot +: 4];
      e.fd  = boundary;
      e.rdy = !modelPending;
      expQ.push_back(e);
      @(posedge clk);
      #1;
      got = expQ.pop_front();
      checkOutput("digit_sel", 32'(digit_sel), 32'(got.sel));
      checkOutput("nibble", 32'(nibble), 32'(got.nib));
      checkOutput("frame_done", 32'(frame_done), 32'(got.fd));
      checkOutput("load_ready", 32'(load_ready), 32'(got.rdy));
      if (xfer) offerOn = 1'b0;
      @(negedge clk);
   endtask

   task automatic runCycles(input int n, input logic enIn);
      for (int i = 0; i < n; i++) applyStimulus(enIn);
   endtask

   // Asserts reset mid-cycle and checks the asynchronous clear before any clock edge.
   task automatic resetDut();
      rst_n = 1'b0;
      #1;
      checkOutput("rst_digit_sel", 32'(digit_sel), 32'h0);
      checkOutput("rst_nibble", 32'(nibble), 32'h0);
      checkOutput("rst_frame_done", 32'(frame_done), 32'h0);
      checkOutput("rst_load_ready", 32'(load_ready), 32'h1);
      expQ.delete();
      offerOn      = 1'b0;
      load_valid   = 1'b0;
      en           = 1'b1;
      scanPos      = 0;
      modelActive  = 16'h0;
      modelShadow  = 16'h0;
      modelPending = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      @(negedge clk);
      resetDut();

      // Idle scan, then a load at cycle 3 and a second load held while the first is pending.
      runCycles(3, 1'b1);
      startOffer(16'h1234);
      runCycles(2, 1'b1);
      startOffer(16'hABCD);
      runCycles(70, 1'b1);

      // Freeze the scan mid-slot of digit 1 while a transfer is still offered.
      while ((scanPos % FRAME) != 12) applyStimulus(1'b1);
      startOffer(16'h0F00);
      runCycles(8, 1'b0);
      runCycles(40, 1'b1);

      // Reset while a value is pending: it must be discarded.
      startOffer(16'h5678);
      runCycles(3, 1'b1);
      resetDut();
      runCycles(40, 1'b1);

      // Values that exercise leading-zero suppression when enabled.
      startOffer(16'h0050);
      runCycles(70, 1'b1);
      startOffer(16'h0000);
      runCycles(70, 1'b1);

      for (int r = 0; r < 4; r++) begin
         startOffer(16'($urandom));
         runCycles(int'($urandom_range(5, 30)), 1'b1);
         runCycles(int'($urandom_range(1, 6)), 1'b0);
         runCycles(30, 1'b1);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
